// File: rtl/count_updw_pkg.sv
// Shared types and constants for the count_updw_multi counter family.
package count_updw_pkg;

    typedef enum logic [1:0] {
        M_UP     = 2'b00,
        M_DOWN   = 2'b01,
        M_BOUNCE = 2'b10,
        M_HOLD   = 2'b11
    } mode_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/count_updw_step.sv
// Combinational next-state logic for one count_updw_multi channel.
// Covers degenerate limits, out-of-range recovery and the UP, DOWN,
// BOUNCE and HOLD steps. Enable and load gating live in the top.
module count_updw_step
    import count_updw_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] count_next,
    output logic             dir_next,
    output logic             tc_next
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_t m;
    assign m = mode_t'(mode);

    // Next count/dir/tc selection.
    // Priority: HOLD, then degenerate limits, then out-of-range recovery,
    // then the normal per-mode step.
    always_comb begin
        count_next = count;
        dir_next   = dir;
        tc_next    = 1'b0;
        if (m != M_HOLD) begin
            if (lo >= hi) begin
                count_next = lo;
            end else if ((count < lo) || (count > hi)) begin
                if (m == M_DOWN) begin
                    count_next = hi;
                    dir_next   = DIR_DN;
                end else begin
                    count_next = lo;
                    dir_next   = DIR_UP;
                end
            end else begin
                case (m)
                    M_UP: begin
                        dir_next = DIR_UP;
                        if (count == hi) begin
                            count_next = lo;
                            tc_next    = 1'b1;
                        end else begin
                            count_next = count + ONE;
                        end
                    end
                    M_DOWN: begin
                        dir_next = DIR_DN;
                        if (count == lo) begin
                            count_next = hi;
                            tc_next    = 1'b1;
                        end else begin
                            count_next = count - ONE;
                        end
                    end
                    M_BOUNCE: begin
                        if (dir == DIR_UP) begin
                            if (count == hi) begin
                                count_next = hi - ONE;
                                dir_next   = DIR_DN;
                                tc_next    = 1'b1;
                            end else begin
                                count_next = count + ONE;
                            end
                        end else begin
                            if (count == lo) begin
                                count_next = lo + ONE;
                                dir_next   = DIR_UP;
                                tc_next    = 1'b1;
                            end else begin
                                count_next = count - ONE;
                            end
                        end
                    end
                    default: begin
                        count_next = count;
                        dir_next   = dir;
                        tc_next    = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/count_updw_multi.sv
// Parametrised up/down/bounce/hold counter with runtime limits,
// registered count, direction and terminal-event pulse.
// Optional macro COUNT_UPDW_MULTI_LOAD_EN adds a synchronous parallel load
// (ports load, load_val) that overrides enable, mode and range checking.
module count_updw_multi
    import count_updw_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
`ifdef COUNT_UPDW_MULTI_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
);

    logic [WIDTH-1:0] count_next;
    logic             dir_next;
    logic             tc_next;

    count_updw_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .count      (count),
        .dir        (dir),
        .mode       (mode),
        .lo         (lo),
        .hi         (hi),
        .count_next (count_next),
        .dir_next   (dir_next),
        .tc_next    (tc_next)
    );

    // State registers: async reset, then load, then enabled step, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            dir   <= DIR_UP;
            tc    <= 1'b0;
        end else begin
`ifdef COUNT_UPDW_MULTI_LOAD_EN
            if (load) begin
                count <= load_val;
                tc    <= 1'b0;
            end else
`endif
            if (en) begin
                count <= count_next;
                dir   <= dir_next;
                tc    <= tc_next;
            end else begin
                tc    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_updw_multi.sv
// Self-checking bench for count_updw_multi (WIDTH=3): directed scenarios
// followed by randomized stimulus, compared against a behavioural model.
module tb_count_updw_multi;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] count;
    logic         dir;
    logic         tc;
`ifdef COUNT_UPDW_MULTI_LOAD_EN
    logic         load;
    logic [W-1:0] load_val;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_count;
    int m_dir;
    int m_tc;

    count_updw_multi #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .lo       (lo),
        .hi       (hi),
`ifdef COUNT_UPDW_MULTI_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .count    (count),
        .dir      (dir),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
        n_tests++;
        if (obs !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".count"}, 32'(count), m_count);
        check_eq({tag, ".dir"},   32'(dir),   m_dir);
        check_eq({tag, ".tc"},    32'(tc),    m_tc);
    endtask

    // One rising edge of the reference behaviour, from the rule table.
    task automatic model_step();
        int c, l, h, md;
        c  = m_count;
        l  = int'(lo);
        h  = int'(hi);
        md = int'(mode);
        m_tc = 0;
`ifdef COUNT_UPDW_MULTI_LOAD_EN
        if (load) begin
            m_count = int'(load_val);
            return;
        end
`endif
        if (!en || md == 3) return;
        if (l >= h) begin
            m_count = l;
            return;
        end
        if (c < l || c > h) begin
            if (md == 1) begin m_count = h; m_dir = 0; end
            else         begin m_count = l; m_dir = 1; end
            return;
        end
        case (md)
            0: begin
                m_dir = 1;
                if (c == h) begin m_count = l; m_tc = 1; end
                else m_count = c + 1;
            end
            1: begin
                m_dir = 0;
                if (c == l) begin m_count = h; m_tc = 1; end
                else m_count = c - 1;
            end
            default: begin
                if (m_dir == 1) begin
                    if (c == h) begin m_count = h - 1; m_dir = 0; m_tc = 1; end
                    else m_count = c + 1;
                end else begin
                    if (c == l) begin m_count = l + 1; m_dir = 1; m_tc = 1; end
                    else m_count = c - 1;
                end
            end
        endcase
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Called at least 1 time unit after a rising edge: assert reset
    // mid-cycle, check the immediate effect, release it in the next cycle.
    task automatic do_reset();
        #1;
        reset = 1'b1;
        #1;
        m_count = 0; m_dir = 1; m_tc = 0;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        mode  = 2'd0;
        lo    = '0;
        hi    = '1;
`ifdef COUNT_UPDW_MULTI_LOAD_EN
        load     = 1'b0;
        load_val = '0;
`endif
        m_count = 0; m_dir = 1; m_tc = 0;
        #1;
        check_all("reset_state");

        // Bounce 0..7..1 from reset
        mode = 2'd2; lo = 3'd0; hi = 3'd7; en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc("bounce");
            if (i == 7) begin
                check_eq("bounce_turn_hi.count", 32'(count), 6);
                check_eq("bounce_turn_hi.tc", 32'(tc), 1);
                check_eq("bounce_turn_hi.dir", 32'(dir), 0);
            end
            if (i == 14) begin
                check_eq("bounce_turn_lo.count", 32'(count), 1);
                check_eq("bounce_turn_lo.tc", 32'(tc), 1);
            end
        end

        // UP within 2..5, recovering from 0
        mode = 2'd0; lo = 3'd2; hi = 3'd5;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc("up");
            if (i == 0) check_eq("up_recover.count", 32'(count), 2);
            if (i == 4) begin
                check_eq("up_wrap.count", 32'(count), 2);
                check_eq("up_wrap.tc", 32'(tc), 1);
            end
        end

        // DOWN within 1..6, recovering from 0 to hi
        mode = 2'd1; lo = 3'd1; hi = 3'd6;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc("down");
            if (i == 0) begin
                check_eq("down_recover.count", 32'(count), 6);
                check_eq("down_recover.tc", 32'(tc), 0);
            end
            if (i == 6) begin
                check_eq("down_wrap.count", 32'(count), 6);
                check_eq("down_wrap.tc", 32'(tc), 1);
            end
        end

        // Bounce to 4, pause with en=0, then async reset mid-cycle
        mode = 2'd2; lo = 3'd0; hi = 3'd7;
        do_reset();
        for (int i = 0; i < 4; i++) cyc("bounce_run");
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("en_low");
            check_eq("en_low_hold.count", 32'(count), 4);
        end
        do_reset();
        en = 1'b1;

        // Degenerate limits, then HOLD
        mode = 2'd0; lo = 3'd5; hi = 3'd5;
        for (int i = 0; i < 3; i++) begin
            cyc("degenerate");
            check_eq("degenerate.count", 32'(count), 5);
        end
`ifdef COUNT_UPDW_MULTI_LOAD_EN
        load = 1'b1; load_val = 3'd3;
        cyc("load3");
        load = 1'b0;
`endif
        mode = 2'd3;
        for (int i = 0; i < 3; i++) cyc("hold");

`ifdef COUNT_UPDW_MULTI_LOAD_EN
        // Load overriding an enabled UP step, then wrap
        mode = 2'd0; lo = 3'd0; hi = 3'd7; en = 1'b1;
        load = 1'b1; load_val = 3'd6;
        cyc("load6");
        check_eq("load6.count", 32'(count), 6);
        load = 1'b0;
        cyc("load_next");
        check_eq("load_next.count", 32'(count), 7);
        cyc("load_wrap");
        check_eq("load_wrap.tc", 32'(tc), 1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                lo = W'($urandom_range(0, 7));
                hi = W'($urandom_range(0, 7));
            end
`ifdef COUNT_UPDW_MULTI_LOAD_EN
            load     = ($urandom_range(0, 19) == 0);
            load_val = W'($urandom_range(0, 7));
`endif
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_updw_multi.md
Name: count_updw_multi

Overview:
- Parametrised successor to the fixed 3-bit up/down sequencer.
- Registered N-bit counter with runtime-selectable mode: up-wrap, down-wrap, bounce (ping-pong) or hold.
- Runtime lower/upper limits, enable gating, direction output and a terminal-event pulse.
- Drives LED/display sequencing and timing-pattern generators in lab top levels; one instance per channel.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; count changes only on clk edges with en=1.
- mode  in  2  mode_t: 00 UP, 01 DOWN, 10 BOUNCE, 11 HOLD.
- lo  in  WIDTH  lower limit, inclusive.
- hi  in  WIDTH  upper limit, inclusive.
- count  out  WIDTH  current count, registered.
- dir  out  1  current direction: 1 = up, 0 = down; registered.
- tc  out  1  terminal pulse; one cycle, registered.

Behaviour:
- Reset (async, any time, including mid-sequence):
  - count=0, dir=1, tc=0.
  - Release takes effect on the first clk edge after reset deasserts.
- All state is updated on the rising edge of clk.
- Outputs are registered only; no combinational path from any input to any output.
- en=0 or mode=HOLD:
  - count and dir hold.
  - tc=0 next cycle.
- Degenerate limits (lo>=hi) with en=1 and mode!=HOLD:
  - count<=lo, dir unchanged, tc<=0.
- Out of range (count<lo or count>hi) with en=1 and mode!=HOLD:
  - UP or BOUNCE: count<=lo, dir<=1.
  - DOWN: count<=hi, dir<=0.
  - tc<=0.
  - This recovery step takes priority over the normal step.
- UP:
  - dir<=1.
  - If count==hi: count<=lo, tc<=1.
  - Else: count<=count+1, tc<=0.
- DOWN:
  - dir<=0.
  - If count==lo: count<=hi, tc<=1.
  - Else: count<=count-1, tc<=0.
- BOUNCE, dir=1:
  - If count==hi: count<=hi-1, dir<=0, tc<=1.
  - Else: count+1.
- BOUNCE, dir=0:
  - If count==lo: count<=lo+1, dir<=1, tc<=1.
  - Else: count-1.
  - Each endpoint appears for exactly one cycle.
  - Period is 2*(hi-lo) enabled cycles; lo=0, hi=7 gives the 14-state sequence 0..7..1.
- Mode change mid-sequence:
  - Takes effect on the next enabled edge from the current count.
  - Switching into BOUNCE keeps the current dir.
- Limit change mid-sequence:
  - Evaluated every edge; no latching of lo/hi.
- Latency:
  - tc is high in the cycle in which count shows the post-wrap or post-turnaround value.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - No overflow is reachable, because of the range check.

Optional Feature:
- Macro: COUNT_UPDW_MULTI_LOAD_EN.
- When defined:
  - Adds ports load (in, 1) and load_val (in, WIDTH).
  - load=1 at an edge: count<=load_val verbatim, tc<=0, dir unchanged.
  - load has priority over en, mode and the range check.
  - An out-of-range loaded value is corrected by the range rule on the next enabled edge.
- When undefined:
  - Ports are absent; behaviour is exactly as above.

Decomposition:
- Package count_updw_pkg:
  - typedef enum logic [1:0] mode_t {M_UP, M_DOWN, M_BOUNCE, M_HOLD}.
  - localparams DIR_UP=1'b1, DIR_DN=1'b0.
- Sub-module count_updw_step:
  - Purely combinational.
  - Inputs: count, dir, mode, lo, hi.
  - Outputs: next count, next dir, tc_next.
  - The top holds the registers, reset, en and load priority.

Test Plan:
- WIDTH=3, lo=0, hi=7, mode=BOUNCE, en=1 from reset, 30 cycles -> count 0,1,..,7,6,..,1,0,1,..; tc=1 when count shows 6 (after 7) and 1 (after 0); dir flips on the same edges.
- mode=UP, lo=2, hi=5, 10 edges -> 2,3,4,5,2,3,4,5,2,3 (first edge recovers from 0 to 2); tc=1 on each 5->2.
- mode=DOWN, lo=1, hi=6 from count=0 -> first edge count=6 (out-of-range recovery, tc=0), then 5,4,3,2,1,6; tc=1 on 1->6.
- BOUNCE running at count=4, dir=1; hold en=0 for 3 cycles -> count stays 4, tc=0. Then assert reset asynchronously mid-cycle -> count=0, dir=1 immediately, before the next clk edge.
- lo=5, hi=5, mode=UP, en=1 -> count=5 every cycle, tc=0. Then switch to mode=HOLD with count=3 -> count stays 3.
- COUNT_UPDW_MULTI_LOAD_EN defined: lo=0, hi=7, UP, load=1 with load_val=6 and en=1 -> count=6, tc=0. Next edge -> 7. Next edge -> 0 with tc=1.
